instr_fetch_unit: RTL and testbench

- Fetch stage of the 8-bit Harvard processor; sits directly upstream of the instruction decoder.
- Owns the program counter and drives the synchronous instruction-memory read port.
- Presents one 32-bit instruction per cycle, with its PC and a valid flag, to the decoder.
- Supports downstream stall, jump/branch redirect with squash of the in-flight fetch, and a HALT opcode that stops fetching.

---
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the synchronous instruction-memory read port
// and presents one instruction per cycle (with its PC) to the decoder.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_RUN    | fetching sequentially; stall/jump/halt may suspend the fetch
// ST_HALTED | HALT presented and retired; no fetch until jump_en or reset
module instr_fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]          HALT_OPCODE = 6'b111111
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   jump_en,
    input  logic [PC_WIDTH-1:0]    jump_addr,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_en,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    output logic                   halted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_nxt;
    logic [PC_WIDTH-1:0]   r_f_pc;
    logic [PC_WIDTH-1:0]   w_f_pc_nxt;
    logic                  r_f_valid;
    logic                  w_f_valid_nxt;
    logic                  w_halt_hit;
    logic                  w_fetch;
    logic [5:0]            w_opcode;

    assign w_opcode   = imem_rdata[INSTR_WIDTH-1 -: 6];

    // HALT retires only once the decoder has actually accepted it (no stall).
    assign w_halt_hit = r_f_valid & (w_opcode == HALT_OPCODE) & ~stall;
    assign w_fetch    = rst_n & (r_state == ST_RUN) & ~stall & ~w_halt_hit & ~jump_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_PC;
            r_f_pc    <= '0;
            r_f_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_f_pc    <= w_f_pc_nxt;
            r_f_valid <= w_f_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_f_pc_nxt    = r_f_pc;
        w_f_valid_nxt = r_f_valid;
        if (jump_en) begin
            // Redirect squashes whatever is in flight and revives a halted core.
            w_state_nxt   = ST_RUN;
            w_pc_nxt      = jump_addr;
            w_f_valid_nxt = 1'b0;
        end else if (w_halt_hit) begin
            w_state_nxt   = ST_HALTED;
            w_f_valid_nxt = 1'b0;
        end else if (w_fetch) begin
            w_f_pc_nxt    = r_pc;
            w_f_valid_nxt = 1'b1;
            w_pc_nxt      = r_pc + PC_WIDTH'(1);
        end
    end

    assign imem_addr   = r_pc;
    assign imem_en     = w_fetch;
    assign instr_valid = r_f_valid & rst_n;
    assign instr       = instr_valid ? imem_rdata : '0;
    assign instr_pc    = r_f_pc;
    assign halted      = (r_state == ST_HALTED) & rst_n;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural fetch model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, jump_en;
    logic [7:0]  jump_addr;
    logic [7:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid, halted;

    logic        rst2_n;
    logic        stall2 = 1'b0, jump2 = 1'b0;
    logic [7:0]  jaddr2 = '0;
    logic [7:0]  imem_addr2;
    logic        imem_en2;
    logic [31:0] imem_rdata2 = '0;
    logic [31:0] instr2;
    logic [7:0]  instr_pc2;
    logic        instr_valid2, halted2;

    logic [31:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    instr_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
    );

    instr_fetch_unit #(.RESET_PC(8'hFE)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .stall(stall2), .jump_en(jump2), .jump_addr(jaddr2),
        .imem_addr(imem_addr2), .imem_en(imem_en2), .imem_rdata(imem_rdata2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .halted(halted2)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memories: data one edge after enable, else hold.
    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= mem[imem_addr];
        if (imem_en2) imem_rdata2 <= mem[imem_addr2];
    end

    // Model: next address to fetch, the instruction currently presented, halt flag.
    logic [7:0] m_next;
    logic [7:0] m_cur;
    bit         m_have;
    bit         m_halt;

    function automatic bit m_hit();
        return rst_n && m_have && (mem[m_cur][31:26] == 6'h3F) && !stall;
    endfunction

    function automatic bit m_en();
        return rst_n && !m_halt && !stall && !jump_en && !m_hit();
    endfunction

    always @(posedge clk) begin
        bit hit, en;
        hit = m_hit();
        en  = m_en();
        if (!rst_n) begin
            m_next = 8'h00; m_cur = 8'h00; m_have = 0; m_halt = 0;
        end else if (jump_en) begin
            m_next = jump_addr; m_have = 0; m_halt = 0;
        end else if (hit) begin
            m_halt = 1; m_have = 0;
        end else if (en) begin
            m_cur = m_next; m_have = 1; m_next = m_next + 8'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_imem_en",   32'(imem_en),     32'(m_en()));
            chk("m_imem_addr", 32'(imem_addr),   32'(m_next));
            chk("m_valid",     32'(instr_valid), 32'(rst_n && m_have));
            chk("m_instr",     instr,            (rst_n && m_have) ? mem[m_cur] : 32'h0);
            chk("m_instr_pc",  32'(instr_pc),    32'(m_cur));
            chk("m_halted",    32'(halted),      32'(rst_n && m_halt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [7:0] pc);
        int k;
        for (k = 0; k < 60; k++) begin
            if (instr_valid && instr_pc == pc) break;
            cyc();
        end
        if (k == 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_pc: instr_pc %h never presented (last %h)", pc, instr_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0400_0000 + 32'(i);
        mem[7] = 32'hFC00_0000;
        rst_n = 0; rst2_n = 0; stall = 0; jump_en = 0; jump_addr = '0;
        cyc(); cyc();
        chk_on = 1'b1;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_en",    32'(imem_en),     32'h0);
        chk("rst_halt",  32'(halted),      32'h0);
        chk("rst_instr", instr,            32'h0);

        rst_n = 1; #1;
        chk("rel_en",    32'(imem_en),     32'h1);
        chk("rel_addr",  32'(imem_addr),   32'h0);
        chk("rel_valid", 32'(instr_valid), 32'h0);
        cyc();
        chk("first_instr", instr,           32'h0400_0000);
        chk("first_pc",    32'(instr_pc),   32'h0);
        chk("first_addr",  32'(imem_addr),  32'h1);

        wait_pc(8'h05);
        stall = 1; #1;
        chk("stall_en", 32'(imem_en), 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_pc",    32'(instr_pc),    32'h5);
            chk("stall_instr", instr,            32'h0400_0005);
            chk("stall_valid", 32'(instr_valid), 32'h1);
        end
        stall = 0;
        cyc();
        chk("post_stall_pc", 32'(instr_pc), 32'h6);
        cyc();
        chk("halt_instr", instr,            32'hFC00_0000);
        chk("halt_pc",    32'(instr_pc),    32'h7);
        chk("halt_pre",   32'(halted),      32'h0);
        cyc();
        chk("halted",      32'(halted),      32'h1);
        chk("halted_val",  32'(instr_valid), 32'h0);
        chk("halted_en",   32'(imem_en),     32'h0);
        chk("halted_addr", 32'(imem_addr),   32'h8);
        cyc();
        chk("halted_hold", 32'(halted), 32'h1);
        jump_en = 1; jump_addr = 8'h10;
        cyc();
        jump_en = 0; #1;
        chk("unhalt",      32'(halted),      32'h0);
        chk("unhalt_addr", 32'(imem_addr),   32'h10);
        chk("unhalt_en",   32'(imem_en),     32'h1);
        cyc();
        chk("resume_pc",    32'(instr_pc), 32'h10);
        chk("resume_instr", instr,         32'h0400_0010);

        wait_pc(8'h13);
        chk("inflight_addr", 32'(imem_addr), 32'h14);
        jump_en = 1; jump_addr = 8'h40;
        cyc();
        jump_en = 0; #1;
        chk("squash_valid", 32'(instr_valid), 32'h0);
        chk("jump_addr",    32'(imem_addr),   32'h40);
        cyc();
        chk("jump_pc",    32'(instr_pc),    32'h40);
        chk("jump_valid", 32'(instr_valid), 32'h1);
        stall = 1; jump_en = 1; jump_addr = 8'h20;
        cyc();
        stall = 0; jump_en = 0; #1;
        chk("sj_valid", 32'(instr_valid), 32'h0);
        chk("sj_addr",  32'(imem_addr),   32'h20);
        cyc();
        chk("sj_pc", 32'(instr_pc), 32'h20);

        stall = 1; rst_n = 0; #1;
        chk("rst_stall_valid", 32'(instr_valid), 32'h0);
        cyc();
        rst_n = 1; stall = 0; #1;
        chk("rst_restart_addr", 32'(imem_addr), 32'h0);
        cyc();
        chk("rst_restart_pc",    32'(instr_pc), 32'h0);
        chk("rst_restart_instr", instr,         32'h0400_0000);

        rst2_n = 1; #1;
        chk("wrap_first_addr", 32'(imem_addr2), 32'hFE);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] epc;
            epc = 8'hFE + 8'(k);
            cyc();
            chk("wrap_pc",    32'(instr_pc2),    32'(epc));
            chk("wrap_valid", 32'(instr_valid2), 32'h1);
            chk("wrap_instr", instr2,            32'h0400_0000 + 32'(epc));
        end
        rst2_n = 0;

        rst_n = 0;
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? {6'h3F, 26'($urandom)}
                                                 : {6'($urandom_range(0, 62)), 26'($urandom)};
        cyc(); cyc();
        rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            stall     = ($urandom_range(0, 9) < 3);
            jump_en   = ($urandom_range(0, 9) == 0);
            jump_addr = 8'($urandom);
            rst_n     = ($urandom_range(0, 49) != 0);
        end
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
